// File: rtl/agc_seq.sv
// AGC sequencer: warm-up, acquisition and tracking control of the AGC enable.
// Optional TRACK-mode update decimation is built when AGC_SEQ_DECIM_EN is defined.
module agc_seq #(
  parameter int REF        = 6553,
  parameter int TOL        = 328,
  parameter int WARMUP     = 2,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4,
  parameter int TIMEOUT    = 1024
`ifdef AGC_SEQ_DECIM_EN
  , parameter int DECIM_LOG2 = 3
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        in_valid,
  input  logic [16:0] mag,
  input  logic        mag_valid,
  output logic        agc_en,
  output logic        locked,
  output logic        acq_timeout,
  output logic [1:0]  state
);

  localparam int WW = $clog2(WARMUP + 1);
  localparam int RW = $clog2(LOCK_CNT + 1);
  localparam int SW = $clog2(TIMEOUT + 1);
  localparam int MW = $clog2(UNLOCK_CNT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WARM  = 2'b01,
    ACQ   = 2'b10,
    TRACK = 2'b11
  } state_t;

  state_t cur, nxt;

  logic [WW-1:0] warm, warm_n, warm_inc;
  logic [RW-1:0] run, run_n, run_inc;
  logic [SW-1:0] smp, smp_n, smp_inc;
  logic [MW-1:0] miss, miss_n, miss_inc;
  logic          tmo, tmo_n;
  logic          en_q, en_n;
  logic          locked_q;

  logic [17:0] diff, adiff;
  logic        in_win;

  // two's-complement difference; |diff| fits comfortably in 18 bits
  assign diff   = {1'b0, mag} - 18'(REF);
  assign adiff  = diff[17] ? 18'(-diff) : diff;
  assign in_win = adiff <= 18'(TOL);

  assign warm_inc = (warm == WW'(WARMUP))     ? warm : warm + WW'(1);
  assign run_inc  = (run  == RW'(LOCK_CNT))   ? run  : run  + RW'(1);
  assign smp_inc  = (smp  == SW'(TIMEOUT))    ? smp  : smp  + SW'(1);
  assign miss_inc = (miss == MW'(UNLOCK_CNT)) ? miss : miss + MW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur      <= IDLE;
      warm     <= '0;
      run      <= '0;
      smp      <= '0;
      miss     <= '0;
      tmo      <= 1'b0;
      en_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      cur      <= nxt;
      warm     <= warm_n;
      run      <= run_n;
      smp      <= smp_n;
      miss     <= miss_n;
      tmo      <= tmo_n;
      en_q     <= en_n;
      locked_q <= (nxt == TRACK);
    end
  end

  always_comb begin
    nxt    = cur;
    warm_n = warm;
    run_n  = run;
    smp_n  = smp;
    miss_n = miss;
    tmo_n  = tmo;
    if (stop) begin
      nxt    = IDLE;
      warm_n = '0;
      run_n  = '0;
      smp_n  = '0;
      miss_n = '0;
    end else begin
      unique case (cur)
        IDLE: if (start) begin
          nxt    = WARM;
          warm_n = '0;
          run_n  = '0;
          smp_n  = '0;
          miss_n = '0;
          tmo_n  = 1'b0;
        end
        WARM: if (in_valid) begin
          warm_n = warm_inc;
          if (warm_inc == WW'(WARMUP)) nxt = ACQ;
        end
        ACQ: if (mag_valid) begin
          smp_n = smp_inc;
          run_n = in_win ? run_inc : '0;
          // lock takes precedence over a coincident timeout
          if (in_win && run_inc == RW'(LOCK_CNT)) begin
            nxt    = TRACK;
            run_n  = '0;
            smp_n  = '0;
            miss_n = '0;
          end else if (smp_inc == SW'(TIMEOUT)) begin
            nxt    = IDLE;
            tmo_n  = 1'b1;
            warm_n = '0;
            run_n  = '0;
            smp_n  = '0;
          end
        end
        TRACK: if (mag_valid) begin
          miss_n = in_win ? '0 : miss_inc;
          if (!in_win && miss_inc == MW'(UNLOCK_CNT)) begin
            nxt    = ACQ;
            run_n  = '0;
            smp_n  = '0;
            miss_n = '0;
          end
        end
      endcase
    end
  end

`ifdef AGC_SEQ_DECIM_EN
  logic [DECIM_LOG2-1:0] decim, decim_n;

  assign decim_n = (cur == TRACK && nxt == TRACK)
                 ? decim + DECIM_LOG2'(in_valid) : '0;
  assign en_n = (nxt == WARM) || (nxt == ACQ) ||
                (nxt == TRACK && decim_n == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) decim <= '0;
    else     decim <= decim_n;
  end
`else
  assign en_n = (nxt != IDLE);
`endif

  // enable is gated by a registered decode so state changes cannot glitch it
  always_comb begin
    agc_en      = in_valid & en_q;
    locked      = locked_q;
    acq_timeout = tmo;
    state       = cur;
  end

endmodule

// File: doc/agc_seq.md
# agc_seq

Sequencer for the AGC datapath of the RACE filter chain. It drives the AGC sample-enable, runs a warm-up / acquisition / tracking state machine from the AGC output magnitude, and reports lock and acquisition timeout. It sits between the sample-rate strobe of the upstream decimator and the AGC `en` input. Its `mag` input is fed from the AGC peak-magnitude register.

## Interface
- `REF`, 6553: target magnitude; matches the AGC reference level.
- `TOL`, 328: lock window half-width; in-window means |mag − REF| ≤ TOL.
- `WARMUP`, 2: in_valid samples discarded after start; covers the AGC pipeline.
- `LOCK_CNT`, 16: consecutive in-window mag samples needed to declare lock.
- `UNLOCK_CNT`, 4: consecutive out-of-window mag samples in TRACK needed to drop lock.
- `TIMEOUT`, 1024: mag samples allowed in ACQ before abandoning.
- `DECIM_LOG2`, 3: TRACK update decimation; used only with `AGC_SEQ_DECIM_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request to begin acquisition.
- `stop` in 1: single-cycle request to return to idle.
- `in_valid` in 1: input sample strobe.
- `mag` in 17: unsigned AGC output magnitude, max 65536.
- `mag_valid` in 1: `mag` is valid this cycle.
- `agc_en` out 1: enable to the AGC datapath.
- `locked` out 1: high while in TRACK.
- `acq_timeout` out 1: sticky flag, set on ACQ timeout, cleared by an accepted `start`.
- `state` out 2: IDLE=00, WARM=01, ACQ=10, TRACK=11.

## Operation
- **IDLE**
  - `agc_en`=0.
  - `start` → WARM; clears `acq_timeout` and all counters.
- **WARM**
  - `agc_en`=`in_valid`.
  - Counts `in_valid` pulses; on the WARMUP-th pulse → ACQ.
  - `mag_valid` is ignored.
- **ACQ**
  - `agc_en`=`in_valid`.
  - Each `mag_valid` increments the sample counter.
  - In-window sample: increments the run counter. Out-of-window sample: clears the run counter.
  - Run counter reaches LOCK_CNT → TRACK.
  - Otherwise, sample counter reaches TIMEOUT → IDLE and sets `acq_timeout`.
  - Lock and timeout on the same sample: lock wins.
- **TRACK**
  - `locked`=1; `agc_en`=`in_valid` (see Configuration).
  - Each out-of-window `mag_valid` increments the miss counter; each in-window one clears it.
  - Miss counter reaches UNLOCK_CNT → ACQ, with run, sample and miss counters cleared.
- **stop**: in any state, `stop` → IDLE next edge and clears counters.
  - `stop` has priority over `start` and all other transitions.
  - `acq_timeout` is unchanged by `stop`.
- `start` outside IDLE is ignored.
- **Window arithmetic**: 18-bit signed `diff` = {1'b0,`mag`} − REF; absolute value compared unsigned with TOL.
  - `mag`=65536 is legal and out-of-window.
- **Counter widths**: $clog2(param+1); counters saturate and never wrap.
- `in_valid` and `mag_valid` may be high in the same cycle; both are processed.

## Timing
- Reset values: `state`=IDLE, `agc_en`=0, `locked`=0, `acq_timeout`=0, all counters 0.
- `agc_en` is combinational: `in_valid` AND a registered state decode. Zero latency; no glitch from `state` changes.
- Transitions happen on the edge after the deciding `start`/`stop`/`in_valid`/`mag_valid` cycle.
- `locked` rises on the same edge that enters TRACK and falls on the edge that leaves it.
- `acq_timeout` rises on the edge that leaves ACQ for IDLE.
- Reset mid-operation returns to IDLE asynchronously. `agc_en` drops immediately.

## Configuration
- **`AGC_SEQ_DECIM_EN` defined**
  - In TRACK, a DECIM_LOG2-bit counter advances per `in_valid` and resets on TRACK entry.
  - `agc_en`=`in_valid` only when the counter is 0, i.e. one update per 2^DECIM_LOG2 samples.
  - WARM and ACQ are unaffected.
- **Not defined**: `agc_en`=`in_valid` in WARM, ACQ and TRACK; the decimation counter is absent.

## Test plan
- **Reset/idle**: assert `rst` mid-ACQ; `in_valid` toggling → `state`=00, `agc_en`=0, `locked`=0 while `rst` high and after release.
- **Acquire**:
  - Stimulus: `start`, 2 `in_valid`, then 16 `mag_valid` with `mag`=6600.
  - Response: `state` 01→10 after the 2nd strobe; →11 and `locked`=1 on the edge after the 16th sample.
  - Window edges: `mag`=6881 counts as in-window; `mag`=6882 clears the run.
- **Timeout**:
  - Stimulus: in ACQ, 1024 samples of `mag`=20000.
  - Response: →IDLE, `acq_timeout`=1, stays 1 until the next `start`.
  - Corner: the 1024th sample is also the 16th in-window → TRACK, no timeout.
- **Unlock**: in TRACK, 3 out-of-window, 1 in-window, then 4 out-of-window → remains TRACK until the 4th consecutive miss, then `state`=10, `locked`=0.
- **stop/start**: `start`+`stop` same cycle in IDLE → stays IDLE; `stop` in TRACK → IDLE next edge; `start` in ACQ → ignored.
- **`AGC_SEQ_DECIM_EN`, DECIM_LOG2=3**: continuous `in_valid` in TRACK → `agc_en` high on the 1st, 9th, 17th strobe only; without the macro, high on every strobe.
